// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and data_memory_controller.
// Issues single controller accesses, or byte-by-byte accesses when a request crosses a line.
module load_store_unit #(
    parameter int unsigned LINE_LOG2 = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [1:0]        mem_write_mode,
    output logic              mem_enable,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_wait
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_SPLIT,
        ST_ERR
    } state_t;

    // Wide enough that line offset + 4 never wraps for any line size.
    localparam int unsigned SUM_W = LINE_LOG2 + 3;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              write_q, write_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       load_buf_q, load_buf_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept;
    logic              req_legal;
    logic              req_cross;
    logic [2:0]        req_size;
    logic [SUM_W-1:0]  off_sum;
    logic [1:0]        last_k;
    logic [1:0]        size_mode;
    logic [31:0]       load_buf_next;
    logic              done;

    function automatic logic is_legal(input logic wr, input logic [2:0] f);
        if (wr) begin
            return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
        end
        return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) ||
               (f == 3'b100) || (f == 3'b101);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] b);
        case (f)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{b[15]}}, b[15:0]};
            3'b100:  return {24'b0, b[7:0]};
            3'b101:  return {16'b0, b[15:0]};
            default: return b;
        endcase
    endfunction

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        off_sum   = SUM_W'(req_addr[LINE_LOG2-1:0]) + SUM_W'(req_size);
        req_cross = off_sum > SUM_W'(2 ** LINE_LOG2);
        req_legal = is_legal(req_write, req_funct3);
    end

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   begin last_k = 2'd0; size_mode = 2'd1; end
            2'b01:   begin last_k = 2'd1; size_mode = 2'd2; end
            default: begin last_k = 2'd3; size_mode = 2'd3; end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        funct3_d       = funct3_q;
        write_d        = write_q;
        k_d            = k_q;
        load_buf_d     = load_buf_q;
        resp_valid_d   = 1'b0;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        mem_enable     = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_write_mode = 2'd0;
        load_buf_next  = load_buf_q;
        done           = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    funct3_d   = req_funct3;
                    write_d    = req_write;
                    k_d        = 2'd0;
                    load_buf_d = '0;
                    if (!req_legal) begin
                        state_d = ST_ERR;
                    end else if (req_cross) begin
                        state_d = ST_SPLIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                mem_enable     = 1'b1;
                mem_addr       = addr_q;
                mem_wdata      = wdata_q;
                mem_write_mode = write_q ? size_mode : 2'd0;
                if (!mem_wait) begin
                    load_buf_next = mem_rdata;
                    load_buf_d    = load_buf_next;
                    done          = 1'b1;
                end
            end
            ST_SPLIT: begin
                mem_enable     = 1'b1;
                mem_addr       = addr_q + ADDR_W'(k_q);
                mem_wdata      = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
                mem_write_mode = write_q ? 2'd1 : 2'd0;
                if (!mem_wait) begin
                    load_buf_next[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
                    load_buf_d = load_buf_next;
                    k_d        = k_q + 2'd1;
                    done       = (k_q == last_k);
                end
            end
            ST_ERR: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Final completion edge: extend the just-assembled buffer, not the stale one.
        if (done) begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_rdata_d = write_q ? 32'd0 : extend(funct3_q, load_buf_next);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            write_q      <= 1'b0;
            k_q          <= '0;
            load_buf_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            write_q      <= write_d;
            k_q          <= k_d;
            load_buf_q   <= load_buf_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model with wait injection,
// response scoreboard, vector table and hand-written multi-cycle sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write_mode;
    logic        mem_enable;
    logic [31:0] mem_rdata;
    logic        mem_wait;

    always #5 clk = ~clk;

    load_store_unit #(.LINE_LOG2(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_mode(mem_write_mode),
        .mem_enable(mem_enable), .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma = mem_addr[7:0];
    assign mem_rdata = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)], mem[8'(ma + 8'd1)], mem[ma]};

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    typedef struct { logic [31:0] addr; logic [1:0] mode; logic [31:0] wdata; } acc_t;
    typedef struct {
        logic wr; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic preset; logic [31:0] mdata; logic [31:0] exp_rdata; logic exp_err;
        int exp_acc; logic [1:0] exp_mode;
    } vec_t;

    exp_t        sb[$];
    acc_t        acc_log[$];
    logic [31:0] wait_addr_log[$];
    vec_t        vecs[$];
    int          wait_left;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic preset(input logic [31:0] addr, input logic [31:0] data);
        for (int b = 0; b < 4; b++) mem[8'(addr[7:0] + b)] = data[8*b +: 8];
    endtask

    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] er, input logic ee,
                         input logic push);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        if (push) sb.push_back('{er, ee});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic latency(input string name, input int exp_cyc);
        int cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) break;
        end
        check(name, cyc, exp_cyc);
        wait_resp();
    endtask

    initial begin
        logic [31:0] wd;
        int          seen;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_wait = 1'b0; wait_left = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        // memory model: decide wait/completion for the coming rising edge
        fork
            forever begin
                @(negedge clk);
                if (mem_enable && wait_left > 0) begin
                    mem_wait = 1'b1;
                    wait_left--;
                    wait_addr_log.push_back(mem_addr);
                end else begin
                    mem_wait = 1'b0;
                    if (mem_enable) begin
                        acc_log.push_back('{mem_addr, mem_write_mode, mem_wdata});
                        for (int b = 0; b < 4; b++) begin
                            if ((mem_write_mode == 2'd1 && b < 1) || (mem_write_mode == 2'd2 && b < 2) ||
                                mem_write_mode == 2'd3)
                                mem[8'(ma + 8'(b))] = mem_wdata[8*b +: 8];
                        end
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (resp_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    end
                end
            end
        join_none

        vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h800000F0, 32'h800000F0, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b000, 32'h41, 32'h0, 1'b1, 32'h00000080, 32'hFFFFFF80, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b100, 32'h41, 32'h0, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b001, 32'h44, 32'h0, 1'b1, 32'h00008001, 32'hFFFF8001, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b101, 32'h44, 32'h0, 1'b1, 32'h00008001, 32'h00008001, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b1, 3'b001, 32'h42, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b0, 1, 2'd2});
        vecs.push_back('{1'b1, 3'b000, 32'h50, 32'h77, 1'b0, 32'h0, 32'h0, 1'b0, 1, 2'd1});
        vecs.push_back('{1'b1, 3'b010, 32'h60, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 1, 2'd3});
        vecs.push_back('{1'b0, 3'b010, 32'h60, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b1, 3'b010, 32'h1E, 32'hAABBCCDD, 1'b0, 32'h0, 32'h0, 1'b0, 4, 2'd1});
        vecs.push_back('{1'b0, 3'b010, 32'h1E, 32'h0, 1'b0, 32'h0, 32'hAABBCCDD, 1'b0, 4, 2'd0});
        vecs.push_back('{1'b0, 3'b010, 32'h3D, 32'h0, 1'b1, 32'h11223344, 32'h11223344, 1'b0, 4, 2'd0});
        vecs.push_back('{1'b0, 3'b010, 32'h3C, 32'h0, 1'b1, 32'h01020304, 32'h01020304, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b001, 32'h4F, 32'h0, 1'b1, 32'h000085FF, 32'hFFFF85FF, 1'b0, 2, 2'd0});
        vecs.push_back('{1'b0, 3'b000, 32'h4F, 32'h0, 1'b1, 32'h000000C3, 32'hFFFFFFC3, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b101, 32'h2E, 32'h0, 1'b1, 32'h0000FEDC, 32'h0000FEDC, 1'b0, 1, 2'd0});
        vecs.push_back('{1'b0, 3'b011, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 2'd0});
        vecs.push_back('{1'b1, 3'b100, 32'h40, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 0, 2'd0});
        vecs.push_back('{1'b0, 3'b111, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 2'd0});
        vecs.push_back('{1'b1, 3'b011, 32'h40, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 0, 2'd0});

        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_mode", {30'b0, mem_write_mode}, 32'd0);
        reset = 1'b0;
        #1 check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (v.preset) preset(v.addr, v.mdata);
            acc_log.delete();
            issue(v.wr, v.f3, v.addr, v.wdata, v.exp_rdata, v.exp_err, 1'b1);
            wait_resp();
            check($sformatf("v%0d_acc_count", i), acc_log.size(), v.exp_acc);
            if (v.exp_acc > 0 && acc_log.size() > 0) begin
                check($sformatf("v%0d_mode", i), {30'b0, acc_log[0].mode}, {30'b0, v.exp_mode});
                check($sformatf("v%0d_addr", i), acc_log[0].addr, v.addr);
            end
        end

        // crossing word store: four byte writes in address order
        wd = 32'hAABBCCDD;
        acc_log.delete();
        issue(1'b1, 3'b010, 32'h1E, wd, 32'h0, 1'b0, 1'b1);
        wait_resp();
        check("split_sw_count", acc_log.size(), 4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            check($sformatf("split_sw_addr%0d", i), acc_log[i].addr, 32'h1E + i);
            check($sformatf("split_sw_mode%0d", i), {30'b0, acc_log[i].mode}, 32'd1);
            check($sformatf("split_sw_wdata%0d", i), acc_log[i].wdata, {24'b0, wd[8*i +: 8]});
        end

        // crossing halfword load with wait on the first byte
        mem[8'h2F] = 8'h34;
        mem[8'h30] = 8'h92;
        acc_log.delete();
        wait_addr_log.delete();
        wait_left = 3;
        issue(1'b0, 3'b001, 32'h2F, 32'h0, 32'hFFFF9234, 1'b0, 1'b1);
        wait_resp();
        check("wait_cycles", wait_addr_log.size(), 3);
        foreach (wait_addr_log[i]) check($sformatf("wait_addr%0d", i), wait_addr_log[i], 32'h2F);
        check("wait_acc_count", acc_log.size(), 2);
        if (acc_log.size() == 2) begin
            check("wait_acc0_addr", acc_log[0].addr, 32'h2F);
            check("wait_acc1_addr", acc_log[1].addr, 32'h30);
        end

        // latencies
        preset(32'h40, 32'h12345678);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0, 1'b1);
        latency("lat_nocross", 2);
        preset(32'h3D, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h3D, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        latency("lat_cross", 5);
        issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
        latency("lat_err", 2);

        // request held while busy must not be taken
        mem[8'h90] = 8'h00;
        acc_log.delete();
        issue(1'b0, 3'b010, 32'h3D, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h90; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp();
        repeat (3) @(negedge clk);
        check("busy_acc_count", acc_log.size(), 4);
        check("busy_no_write", {24'b0, mem[8'h90]}, 32'h0);

        // reset in the middle of a split load
        acc_log.delete();
        issue(1'b0, 3'b010, 32'h3D, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("abort_mem_enable", {31'b0, mem_enable}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd0);
        check("abort_acc_count", acc_log.size(), 2);
        @(negedge clk);
        reset = 1'b0;
        #1 check("abort_ready_after", {31'b0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d/%0d, expected completion", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
